// File: rtl/gf_mult_seq_if.sv
// Operand/result handshake bundle for the sequential GF(2^N) multiply-add unit.
// The master drives the operands and out_ready; the slave returns the result and status.
interface gf_mult_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N:0]   prim;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         busy;

    modport master (
        output in_valid, a, b, c, prim, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, c, prim, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/gf_mult_seq.sv
// Sequential GF(2^N) multiply-add: out = (a*b mod prim) ^ c.
// Each BUSY cycle consumes D bits of b, MSB first, in a Horner-style shift/reduce/add loop.
module gf_mult_seq #(
    parameter int N = 8,
    parameter int D = 1
) (
    input logic          clk,
    input logic          rst_n,
    gf_mult_seq_if.slave bus
);
    localparam int STEPS = N / D;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic           en_q;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   c_q, c_d;
    logic [N-1:0]   p_q, p_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_nxt;
    logic           accept;
    logic           prim_msb_unused;

    // The leading coefficient of prim is implicit; only prim[N-1:0] enters the reduction.
    assign prim_msb_unused = bus.prim[N];

    function automatic logic [N-1:0] gf_steps(
        input logic [N-1:0] acc,
        input logic [N-1:0] mcand,
        input logic [N-1:0] poly,
        input logic [D-1:0] bits
    );
        logic [N-1:0] r;
        logic         msb;
        r = acc;
        for (int i = D - 1; i >= 0; i--) begin
            msb = r[N-1];
            r   = r << 1;
            if (msb)     r = r ^ poly;
            if (bits[i]) r = r ^ mcand;
        end
        return r;
    endfunction

    assign acc_nxt = gf_steps(acc_q, a_q, p_q, b_q[N-1 -: D]);
    assign accept  = bus.in_valid && (state_q == IDLE) && en_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.c;
                    p_d     = bus.prim[N-1:0];
                    acc_d   = '0;
                    cnt_d   = CW'(STEPS);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_nxt;
                b_d   = b_q << D;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    out_d   = acc_nxt ^ c_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // en_q keeps in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && en_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out       = out_q;
endmodule

// File: doc/gf_mult_seq.md
GF_MULT_SEQ -- requirements
Module: gf_mult_seq

Interface
REQ-001 SHALL have parameter N, default 8: field degree; operand and result width in bits.
REQ-002 SHALL have parameter D, default 1: multiplier bits of b consumed per clock; legal values satisfy 1 <= D <= N and N % D == 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b, c and prim are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have port a, input, N bits: multiplicand.
REQ-008 SHALL have port b, input, N bits: multiplier.
REQ-009 SHALL have port c, input, N bits: addend, XORed into the product.
REQ-010 SHALL have port prim, input, N+1 bits: primitive polynomial; prim[N] is ignored and treated as 1.
REQ-011 SHALL have port out_valid, output, 1 bit: out holds a valid result.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts out.
REQ-013 SHALL have port out, output, N bits: result (a*b mod prim) XOR c.
REQ-014 SHALL have port busy, output, 1 bit: high in BUSY and DONE.

Function
REQ-015 SHALL implement three states: IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL treat the edge where in_valid=1 and in_ready=1 as acceptance: capture a, b, c and prim[N-1:0]; clear acc to 0; load step counter with N/D; go to BUSY.
REQ-018 SHALL ignore input changes after acceptance; registered copies are used.
REQ-019 SHALL, on each BUSY edge, process the next D bits of the captured b, MSB first; per bit: acc = acc<<1 truncated to N bits, XOR prim[N-1:0] if the old acc[N-1] was 1; then XOR a if the bit is 1.
REQ-020 SHALL decrement the step counter each BUSY edge; on the edge the counter reaches 0, go to DONE and register out = acc_final XOR c.
REQ-021 SHALL raise out_valid exactly N/D edges after the acceptance edge (N=8, D=1: 8 cycles; D=8: 1 cycle).
REQ-022 SHALL hold out and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge; out keeps its last value afterwards.
REQ-023 SHALL NOT accept a new operation in the cycle that DONE hands off; the next acceptance occurs no earlier than the following edge.
REQ-024 SHALL produce out=c when a=0 or b=0, and out=a XOR c when b=1.
REQ-025 SHALL generate no error for an illegal D; legality is a static parameter constraint checked in simulation.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, force IDLE, in_ready=0 during reset, out_valid=0, busy=0, out=0, and acc, counter and operand registers to 0.
REQ-027 SHALL abort any operation in progress when reset is asserted mid-operation, with no result emitted; in_ready=1 on the first edge after rst_n rises.

Verification
REQ-028 SHALL pass this test: N=8, D=1, prim=9'h11d, a=8'h5f, b=8'hd3, c=0 -> out=8'h9a, out_valid rising 8 edges after acceptance.
REQ-029 SHALL pass this test: N=8, D=4, same operands, c=8'hff -> out=8'h65 after 2 BUSY edges.
REQ-030 SHALL pass this test: prim=9'h11d, a=8'h02, b=8'h80, c=0 -> out=8'h1d (reduction path); a=8'h00 with any b -> out=c.
REQ-031 SHALL pass this test: out_ready held 0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 SHALL pass this test: rst_n pulsed low at the 3rd BUSY cycle -> all outputs 0 immediately, no out_valid; a new operation afterwards gives the correct result.
REQ-033 SHALL pass this test: random a, b, c, D in {1,2,4,8} vs a bitwise reference model -> 10k operations match.
